// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst-length helper for the bus arbiter slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Undefined-length INCR reports 0 beats.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:               burst_beats = 5'd1;
      HBURST_INCR:                 burst_beats = 5'd0;
      HBURST_WRAP4, HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:  burst_beats = 5'd8;
      default:                     burst_beats = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after the pointer wins.
module ahb_rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int MW          = 1
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [MW-1:0]          i_ptr,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic [MW-1:0]          o_idx,
  output logic                   o_valid
);

  logic [MW-1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_cand = MW'((int'(i_ptr) + i) % NUM_MASTERS);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant, burst/lock ownership hold, and the
// address-phase / data-phase owner pipeline that steers the master muxes.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic                   hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock,
  output logic                   burst_active
);

  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e             r_state;
  logic [MW-1:0]          r_grant_idx;
  logic [MW-1:0]          r_ptr;
  logic [3:0]             r_cnt;
  logic                   r_lock_grant;

  logic [4:0]             w_beats;
  logic                   w_fixed;
  logic                   w_last;
  logic                   w_incr_drop;
  logic                   w_unlock;
  logic                   w_arb;
  logic [3:0]             w_cnt_nxt;
  logic                   w_lock_nxt;
  logic [NUM_MASTERS-1:0] w_pick_gnt;
  logic [MW-1:0]          w_pick_idx;
  logic                   w_pick_vld;

  ahb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .MW          (MW)
  ) u_picker (
    .i_req   (hbusreq),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  assign hmastlock    = (r_state == ST_LOCKED);
  assign burst_active = (r_cnt != 4'd0);

  assign w_beats     = burst_beats(hburst);
  assign w_fixed     = (w_beats > 5'd1);
  // Ownership may change after a 1-beat NONSEQ or the final SEQ of a fixed burst.
  assign w_last      = ((htrans == HTRANS_SEQ) && w_fixed && (r_cnt == 4'd1)) ||
                       ((htrans == HTRANS_NONSEQ) && (w_beats == 5'd1));
  assign w_incr_drop = (hburst == HBURST_INCR) && (htrans != HTRANS_IDLE) && !hbusreq[hmaster];
  assign w_unlock    = hmastlock && ((htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ)) &&
                       !hlock[hmaster];
  assign w_arb       = hready && (hmastlock ? w_unlock :
                       ((htrans == HTRANS_IDLE) || w_last || w_incr_drop || hresp));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (hready) begin
      if (hresp)
        w_cnt_nxt = 4'd0;
      else if (htrans == HTRANS_NONSEQ)
        w_cnt_nxt = (w_beats == 5'd0) ? 4'd0 : 4'(w_beats - 5'd1);
      else if ((htrans == HTRANS_SEQ) && (r_cnt != 4'd0))
        w_cnt_nxt = r_cnt - 4'd1;
    end
  end

  // The lock follows the grant into the address phase, one hready edge later.
  assign w_lock_nxt = !hready ? hmastlock : (hmastlock ? !w_unlock : r_lock_grant);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant       <= DEF_GNT;
      r_grant_idx  <= DEF_IDX;
      hmaster      <= DEF_IDX;
      hmaster_data <= DEF_IDX;
      r_ptr        <= DEF_IDX;
      r_cnt        <= 4'd0;
      r_lock_grant <= 1'b0;
      r_state      <= ST_FREE;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_lock_nxt)
        r_state <= ST_LOCKED;
      else if (w_cnt_nxt != 4'd0)
        r_state <= ST_BURST;
      else
        r_state <= ST_FREE;
      if (hready) begin
        hmaster      <= r_grant_idx;
        hmaster_data <= hmaster;
      end
      if (w_arb) begin
        if (w_pick_vld) begin
          hgrant       <= w_pick_gnt;
          r_grant_idx  <= w_pick_idx;
          r_ptr        <= w_pick_idx;
          r_lock_grant <= hlock[w_pick_idx];
        end else begin
          hgrant       <= DEF_GNT;
          r_grant_idx  <= DEF_IDX;
          r_lock_grant <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter with two masters: directed scenarios
// plus a random phase, all checked against a cycle model of the arbiter.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [1:0] hbusreq, hlock, htrans;
  logic [2:0] hburst;
  logic       hready, hresp;
  logic [1:0] hgrant;
  logic [0:0] hmaster, hmaster_data;
  logic       hmastlock, burst_active;

  typedef struct packed {
    logic [1:0] grant;
    logic       master;
    logic       mdata;
    logic       lock;
    logic       bact;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  logic [1:0] m_grant;
  logic       m_gidx, m_master, m_mdata, m_lock, m_lockg, m_ptr;
  logic [3:0] m_cnt;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter #(
    .NUM_MASTERS    (2),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk         (hclk),
    .hreset       (hreset),
    .hbusreq      (hbusreq),
    .hlock        (hlock),
    .htrans       (htrans),
    .hburst       (hburst),
    .hready       (hready),
    .hresp        (hresp),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmastlock    (hmastlock),
    .burst_active (burst_active)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] tb_beats(input logic [2:0] b);
    case (b)
      3'd0:       return 5'd1;
      3'd1:       return 5'd0;
      3'd2, 3'd3: return 5'd4;
      3'd4, 3'd5: return 5'd8;
      default:    return 5'd16;
    endcase
  endfunction

  // Predicts the register state right after the coming rising edge.
  task automatic model_step();
    logic [4:0] bt;
    logic       arb;
    logic       other;
    if (hreset) begin
      m_grant = 2'b01; m_gidx = 1'b0; m_master = 1'b0; m_mdata = 1'b0;
      m_lock = 1'b0; m_lockg = 1'b0; m_cnt = 4'd0; m_ptr = 1'b0;
    end else if (hready) begin
      bt = tb_beats(hburst);
      if (m_lock)
        arb = ((htrans == T_IDLE) || (htrans == T_NSEQ)) && !hlock[m_master];
      else
        arb = (htrans == T_IDLE) || ((htrans == T_NSEQ) && (bt == 5'd1)) ||
              ((htrans == T_SEQ) && (bt > 5'd1) && (m_cnt == 4'd1)) ||
              ((hburst == B_INCR) && (htrans != T_IDLE) && !hbusreq[m_master]) || hresp;
      m_mdata  = m_master;
      m_master = m_gidx;
      m_lock   = m_lock ? !arb : m_lockg;
      if (hresp) m_cnt = 4'd0;
      else if (htrans == T_NSEQ) m_cnt = (bt == 5'd0) ? 4'd0 : 4'(bt - 5'd1);
      else if ((htrans == T_SEQ) && (m_cnt != 4'd0)) m_cnt = m_cnt - 4'd1;
      if (arb) begin
        other = ~m_ptr;
        if (hbusreq[other]) begin
          m_gidx = other; m_ptr = other; m_lockg = hlock[other];
        end else if (hbusreq[m_ptr]) begin
          m_gidx = m_ptr; m_lockg = hlock[m_ptr];
        end else begin
          m_gidx = 1'b0; m_lockg = 1'b0;
        end
        m_grant = m_gidx ? 2'b10 : 2'b01;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] tr, input logic [2:0] bu,
                      input logic [1:0] rq, input logic [1:0] lk,
                      input logic rdy, input logic rsp);
    exp_t e;
    @(negedge hclk);
    hreset = rst; htrans = tr; hburst = bu; hbusreq = rq; hlock = lk;
    hready = rdy; hresp = rsp;
    model_step();
    sb_q.push_back('{m_grant, m_master, m_mdata, m_lock, (m_cnt != 4'd0)});
    @(posedge hclk);
    #1;
    chk("sb_level", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("hgrant", hgrant, e.grant);
      chk("hmaster", hmaster, e.master);
      chk("hmaster_data", hmaster_data, e.mdata);
      chk("hmastlock", hmastlock, e.lock);
      chk("burst_active", burst_active, e.bact);
    end
  endtask

  task automatic go(input logic [1:0] tr, input logic [2:0] bu, input logic [1:0] rq,
                    input logic [1:0] lk, input logic rdy, input logic rsp);
    step(1'b0, tr, bu, rq, lk, rdy, rsp);
  endtask

  initial begin
    int ba_cnt;
    logic [1:0] lk;

    step(1'b1, T_IDLE, B_SINGLE, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b1, T_IDLE, B_SINGLE, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("rst_hgrant", hgrant, 2'b01);
    chk("rst_hmaster", hmaster, 0);
    chk("rst_hmaster_data", hmaster_data, 0);
    chk("rst_hmastlock", hmastlock, 0);
    chk("rst_burst_active", burst_active, 0);

    for (int i = 0; i < 10; i++) begin
      go(T_IDLE, B_SINGLE, 2'b00, 2'b00, 1'b1, 1'b0);
      chk("idle_hgrant", hgrant, 2'b01);
      chk("idle_hmaster", hmaster, 0);
      chk("idle_hmastlock", hmastlock, 0);
    end

    // master0 INCR4 while both request
    go(T_NSEQ, B_INCR4, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("incr4_hold", hgrant, 2'b01);
    go(T_SEQ, B_INCR4, 2'b11, 2'b00, 1'b1, 1'b0);
    go(T_SEQ, B_INCR4, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("incr4_hold_b3", hgrant, 2'b01);
    go(T_SEQ, B_INCR4, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("incr4_handover", hgrant, 2'b10);
    chk("incr4_hmaster_old", hmaster, 0);
    go(T_IDLE, B_SINGLE, 2'b10, 2'b00, 1'b1, 1'b0);
    chk("incr4_hmaster_new", hmaster, 1);

    // master1 INCR8 with a three-cycle stall at beat 5
    ba_cnt = 0;
    go(T_NSEQ, B_INCR8, 2'b11, 2'b00, 1'b1, 1'b0);
    ba_cnt += int'(burst_active);
    chk("incr4_hmaster_data", hmaster_data, 1);
    for (int i = 0; i < 3; i++) begin
      go(T_SEQ, B_INCR8, 2'b11, 2'b00, 1'b1, 1'b0);
      ba_cnt += int'(burst_active);
    end
    for (int i = 0; i < 3; i++) begin
      go(T_SEQ, B_INCR8, 2'b11, 2'b00, 1'b0, 1'b0);
      chk("stall_hgrant", hgrant, 2'b10);
      chk("stall_hmaster", hmaster, 1);
      chk("stall_burst_active", burst_active, 1);
    end
    for (int i = 0; i < 3; i++) begin
      go(T_SEQ, B_INCR8, 2'b11, 2'b00, 1'b1, 1'b0);
      ba_cnt += int'(burst_active);
      chk("incr8_hold", hgrant, 2'b10);
    end
    go(T_SEQ, B_INCR8, 2'b11, 2'b00, 1'b1, 1'b0);
    ba_cnt += int'(burst_active);
    chk("incr8_handover", hgrant, 2'b01);
    chk("incr8_active_beats", ba_cnt, 7);

    // master0 locked SINGLEs, master1 waiting
    go(T_IDLE, B_SINGLE, 2'b01, 2'b01, 1'b1, 1'b0);
    go(T_IDLE, B_SINGLE, 2'b01, 2'b01, 1'b1, 1'b0);
    chk("lock_on", hmastlock, 1);
    for (int i = 0; i < 3; i++) begin
      go(T_NSEQ, B_SINGLE, 2'b11, 2'b01, 1'b1, 1'b0);
      chk("lock_hgrant", hgrant, 2'b01);
      chk("lock_held", hmastlock, 1);
    end
    go(T_IDLE, B_SINGLE, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("unlock_hgrant", hgrant, 2'b10);
    chk("unlock_hmastlock", hmastlock, 0);

    // master0 INCR16 terminated by an error at beat 6
    go(T_IDLE, B_SINGLE, 2'b01, 2'b00, 1'b1, 1'b0);
    go(T_IDLE, B_SINGLE, 2'b01, 2'b00, 1'b1, 1'b0);
    chk("err_owner", hmaster, 0);
    go(T_NSEQ, B_INCR16, 2'b11, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) go(T_SEQ, B_INCR16, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("err_pre_active", burst_active, 1);
    chk("err_pre_hgrant", hgrant, 2'b01);
    go(T_SEQ, B_INCR16, 2'b11, 2'b00, 1'b1, 1'b1);
    chk("err_burst_active", burst_active, 0);
    chk("err_hgrant", hgrant, 2'b10);

    // reset in the middle of a master1 INCR8
    go(T_IDLE, B_SINGLE, 2'b10, 2'b00, 1'b1, 1'b0);
    go(T_NSEQ, B_INCR8, 2'b11, 2'b00, 1'b1, 1'b0);
    go(T_SEQ, B_INCR8, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("mid_owner", hmaster, 1);
    chk("mid_active", burst_active, 1);
    step(1'b1, T_SEQ, B_INCR8, 2'b11, 2'b00, 1'b1, 1'b0);
    chk("midrst_hgrant", hgrant, 2'b01);
    chk("midrst_hmaster", hmaster, 0);
    chk("midrst_hmastlock", hmastlock, 0);
    chk("midrst_burst_active", burst_active, 0);

    for (int i = 0; i < 400; i++) begin
      lk = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), lk, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0));
      chk("onehot", int'($countones(hgrant)), 1);
    end

    chk("sb_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
